// File: rtl/cuckoo_probe_unit_if.sv
// Command/response bundle for cuckoo_probe_unit: one command in, one result out.
// Handshake: a transfer happens on a rising edge where valid and ready are both 1;
// a producer holding valid=1 keeps its payload stable until that edge.
interface cuckoo_probe_unit_if #(
  parameter int LG_NUM_BUCKETS = 2,
  parameter int VAL_W          = 32
) ();
  logic                      cmd_valid;
  logic                      cmd_ready;
  logic [1:0]                cmd_op;
  logic [63:0]               cmd_key;
  logic [VAL_W-1:0]          cmd_val;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic                      rsp_hit;
  logic                      rsp_full;
  logic                      rsp_way;
  logic [LG_NUM_BUCKETS-1:0] rsp_idx;
  logic [VAL_W-1:0]          rsp_val;
  logic [LG_NUM_BUCKETS+1:0] occupancy;

  modport master (
    output cmd_valid, cmd_op, cmd_key, cmd_val, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_hit, rsp_full, rsp_way, rsp_idx, rsp_val, occupancy
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_key, cmd_val, rsp_ready,
    output cmd_ready, rsp_valid, rsp_hit, rsp_full, rsp_way, rsp_idx, rsp_val, occupancy
  );
endinterface

// File: rtl/cuckoo_probe_unit.sv
// Two-way cuckoo hash probe engine: multiply-shift hashing, then lookup / insert
// (no eviction) / delete against two on-chip bucket tables, one command at a time.
module cuckoo_probe_unit #(
  parameter int          LG_NUM_BUCKETS = 2,
  parameter int          VAL_W          = 32,
  parameter logic [31:0] COE_A0         = 32'h6f23ffab,
  parameter logic [31:0] COE_B0         = 32'h1f23ffab,
  parameter logic [31:0] COE_A1         = 32'h1f23ffab,
  parameter logic [31:0] COE_B1         = 32'h6f23ffab
) (
  input  logic                  clk,
  input  logic                  rst,
  cuckoo_probe_unit_if.slave    io_bus,
  output logic [1:0]            o_dbg_state
);
  localparam int NB    = 1 << LG_NUM_BUCKETS;
  localparam int OCC_W = LG_NUM_BUCKETS + 2;
  localparam int LG    = LG_NUM_BUCKETS;

  typedef enum logic [1:0] {S_IDLE, S_HASH, S_PROBE, S_RESP} state_t;

  state_t            r_state, w_next;
  logic [1:0]        r_op;
  logic [63:0]       r_key;
  logic [VAL_W-1:0]  r_val;
  logic [LG-1:0]     r_h0, r_h1;
  logic [NB-1:0]     r_v0, r_v1;
  logic [63:0]       r_k0 [NB];
  logic [63:0]       r_k1 [NB];
  logic [VAL_W-1:0]  r_d0 [NB];
  logic [VAL_W-1:0]  r_d1 [NB];
  logic [OCC_W-1:0]  r_occ;
  logic              r_rsp_hit, r_rsp_full, r_rsp_way;
  logic [LG-1:0]     r_rsp_idx;
  logic [VAL_W-1:0]  r_rsp_val;

  logic              w_accept, w_probe, w_m0, w_m1, w_hit, w_is_ins, w_is_del;
  logic              w_wr0, w_wr1, w_clr0, w_clr1, w_full, w_way;
  logic [VAL_W-1:0]  w_val;
  logic [LG-1:0]     w_h0, w_h1, w_idx;

  // Full 64-bit wrapping sum of two 32x32 products; the index is its top bits.
  function automatic logic [LG-1:0] f_hash(input logic [63:0] key,
                                           input logic [31:0] a, input logic [31:0] b);
    logic [63:0] s;
    s = ({32'd0, key[63:32]} * {32'd0, a}) + ({32'd0, key[31:0]} * {32'd0, b});
    return s[63 -: LG];
  endfunction

  assign w_h0     = f_hash(r_key, COE_A0, COE_B0);
  assign w_h1     = f_hash(r_key, COE_A1, COE_B1);
  assign w_accept = io_bus.cmd_valid && io_bus.cmd_ready;
  assign w_probe  = (r_state == S_PROBE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_HASH;
      S_HASH:  w_next = S_PROBE;
      S_PROBE: w_next = S_RESP;
      S_RESP:  if (io_bus.rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Probe decision; op 3 falls through as a plain lookup.
  always_comb begin
    w_m0     = r_v0[r_h0] && (r_k0[r_h0] == r_key);
    w_m1     = r_v1[r_h1] && (r_k1[r_h1] == r_key);
    w_hit    = w_m0 || w_m1;
    w_is_ins = (r_op == 2'd1);
    w_is_del = (r_op == 2'd2);
    w_wr0    = 1'b0;
    w_wr1    = 1'b0;
    w_clr0   = 1'b0;
    w_clr1   = 1'b0;
    w_full   = 1'b0;
    w_way    = 1'b0;
    w_val    = '0;
    if (w_m0) begin
      w_val = r_d0[r_h0];
    end else if (w_m1) begin
      w_way = 1'b1;
      w_val = r_d1[r_h1];
    end
    if (w_is_ins) begin
      if (w_m0)              w_wr0 = 1'b1;
      else if (w_m1)         w_wr1 = 1'b1;
      else if (!r_v0[r_h0])  w_wr0 = 1'b1;
      else if (!r_v1[r_h1]) begin
        w_wr1 = 1'b1;
        w_way = 1'b1;
      end else               w_full = 1'b1;
    end
    if (w_is_del) begin
      w_clr0 = w_m0;
      w_clr1 = !w_m0 && w_m1;
    end
    w_idx = w_way ? r_h1 : r_h0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op  <= '0;
      r_key <= '0;
      r_val <= '0;
      r_h0  <= '0;
      r_h1  <= '0;
    end else begin
      if (w_accept) begin
        r_op  <= io_bus.cmd_op;
        r_key <= io_bus.cmd_key;
        r_val <= io_bus.cmd_val;
      end
      if (r_state == S_HASH) begin
        r_h0 <= w_h0;
        r_h1 <= w_h1;
      end
    end
  end

  // Reset forces S_IDLE asynchronously, so no table write can follow rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v0       <= '0;
      r_v1       <= '0;
      r_occ      <= '0;
      r_rsp_hit  <= 1'b0;
      r_rsp_full <= 1'b0;
      r_rsp_way  <= 1'b0;
      r_rsp_idx  <= '0;
      r_rsp_val  <= '0;
    end else if (w_probe) begin
      if (w_wr0)  r_v0[r_h0] <= 1'b1;
      if (w_wr1)  r_v1[r_h1] <= 1'b1;
      if (w_clr0) r_v0[r_h0] <= 1'b0;
      if (w_clr1) r_v1[r_h1] <= 1'b0;
      if (w_is_ins && !w_hit && !w_full) r_occ <= r_occ + OCC_W'(1);
      if (w_is_del && w_hit)             r_occ <= r_occ - OCC_W'(1);
      r_rsp_hit  <= w_hit;
      r_rsp_full <= w_full;
      r_rsp_way  <= w_way;
      r_rsp_idx  <= w_idx;
      r_rsp_val  <= w_val;
    end
  end

  always_ff @(posedge clk) begin
    if (w_probe && w_wr0) begin
      r_k0[r_h0] <= r_key;
      r_d0[r_h0] <= r_val;
    end
    if (w_probe && w_wr1) begin
      r_k1[r_h1] <= r_key;
      r_d1[r_h1] <= r_val;
    end
  end

  assign io_bus.cmd_ready = (r_state == S_IDLE);
  assign io_bus.rsp_valid = (r_state == S_RESP);
  assign io_bus.rsp_hit   = r_rsp_hit;
  assign io_bus.rsp_full  = r_rsp_full;
  assign io_bus.rsp_way   = r_rsp_way;
  assign io_bus.rsp_idx   = r_rsp_idx;
  assign io_bus.rsp_val   = r_rsp_val;
  assign io_bus.occupancy = r_occ;
  assign o_dbg_state      = r_state;
endmodule

// File: tb/tb_cuckoo_probe_unit.sv
// Bench for cuckoo_probe_unit: directed test-plan steps, randomized ops and a
// table-level reference model of the two hash ways.
module tb_cuckoo_probe_unit;
  localparam int LG = 2;
  localparam int NB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dbg_state;
  int         n_vec  = 0;
  int         n_miss = 0;

  cuckoo_probe_unit_if #(.LG_NUM_BUCKETS(LG), .VAL_W(32)) bus ();

  cuckoo_probe_unit #(.LG_NUM_BUCKETS(LG), .VAL_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .io_bus      (bus.slave),
    .o_dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // Reference tables
  logic        m_v   [2][NB];
  logic [63:0] m_k   [2][NB];
  logic [31:0] m_d   [2][NB];
  int          m_occ;
  logic [31:0] last_idx;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int mhash(input logic [63:0] key, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] s;
    s = 64'(key[63:32]) * 64'(a) + 64'(key[31:0]) * 64'(b);
    return int'(s >> (64 - LG));
  endfunction

  task automatic model_clear();
    for (int w = 0; w < 2; w++)
      for (int i = 0; i < NB; i++) m_v[w][i] = 1'b0;
    m_occ = 0;
  endtask

  task automatic do_cmd(input logic [1:0] op, input logic [63:0] key,
                        input logic [31:0] val, input int hold);
    int   ix [2];
    logic e_hit, e_full, e_way;
    logic [31:0] e_val;
    int   cyc;
    ix[0] = mhash(key, 32'h6f23ffab, 32'h1f23ffab);
    ix[1] = mhash(key, 32'h1f23ffab, 32'h6f23ffab);
    e_hit = 0; e_full = 0; e_way = 0; e_val = 0;
    for (int w = 0; w < 2; w++)
      if (!e_hit && m_v[w][ix[w]] && m_k[w][ix[w]] == key) begin
        e_hit = 1; e_way = w[0]; e_val = m_d[w][ix[w]];
      end
    if (op == 2'd1) begin
      if (e_hit) m_d[e_way][ix[e_way]] = val;
      else begin
        if (!m_v[0][ix[0]]) e_way = 0;
        else if (!m_v[1][ix[1]]) e_way = 1;
        else e_full = 1;
        if (!e_full) begin
          m_v[e_way][ix[e_way]] = 1; m_k[e_way][ix[e_way]] = key;
          m_d[e_way][ix[e_way]] = val; m_occ++;
        end
      end
    end else if (op == 2'd2 && e_hit) begin
      m_v[e_way][ix[e_way]] = 0; m_occ--;
    end

    @(negedge clk);
    check("cmd_ready_idle", bus.cmd_ready, 1);
    bus.cmd_valid = 1; bus.cmd_op = op; bus.cmd_key = key; bus.cmd_val = val;
    @(posedge clk); #1;
    bus.cmd_valid = 0;
    cyc = 1;
    while (!bus.rsp_valid && cyc < 12) begin
      @(posedge clk); #1; cyc++;
    end
    check("latency", cyc, 3);
    @(negedge clk);
    check("rsp_valid", bus.rsp_valid, 1);
    check("rsp_hit",  bus.rsp_hit,  e_hit);
    check("rsp_full", bus.rsp_full, e_full);
    check("rsp_way",  bus.rsp_way,  e_way);
    check("rsp_idx",  bus.rsp_idx,  e_way ? ix[1] : ix[0]);
    check("rsp_val",  bus.rsp_val,  e_val);
    check("occupancy", bus.occupancy, m_occ);
    last_idx = 32'(bus.rsp_idx);
    // Stall with a competing command presented; it must not be sampled.
    for (int h = 0; h < hold; h++) begin
      bus.cmd_valid = 1; bus.cmd_op = 2'd1; bus.cmd_key = 64'hdead; bus.cmd_val = 32'h1234;
      @(negedge clk);
      check("hold_valid", bus.rsp_valid, 1);
      check("hold_ready", bus.cmd_ready, 0);
      check("hold_hit",   bus.rsp_hit,   e_hit);
      check("hold_val",   bus.rsp_val,   e_val);
      check("hold_idx",   bus.rsp_idx,   e_way ? ix[1] : ix[0]);
    end
    bus.cmd_valid = 0;
    bus.rsp_ready = 1;
    @(posedge clk); #1;
    bus.rsp_ready = 0;
    check("rsp_drop", bus.rsp_valid, 0);
  endtask

  logic [63:0] pool [8];

  initial begin
    bus.cmd_valid = 0; bus.cmd_op = 0; bus.cmd_key = 0; bus.cmd_val = 0; bus.rsp_ready = 0;
    last_idx = 0;
    model_clear();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_occ", bus.occupancy, 0);
    rst = 0;
    @(negedge clk);
    check("rst_cmd_ready", bus.cmd_ready, 1);
    check("rst_state", dbg_state, 0);
    check("rst_rsp_hit", bus.rsp_hit, 0);
    check("rst_rsp_full", bus.rsp_full, 0);
    check("rst_rsp_way", bus.rsp_way, 0);
    check("rst_rsp_idx", bus.rsp_idx, 0);
    check("rst_rsp_val", bus.rsp_val, 0);

    do_cmd(2'd0, 64'h1, 0, 0);
    do_cmd(2'd1, 64'h1, 32'hA, 0);
    do_cmd(2'd1, 64'h2, 32'hB, 0);
    do_cmd(2'd1, 64'h3, 32'hC, 0);
    check("fill_occ", bus.occupancy, 2);
    do_cmd(2'd1, 64'h1, 32'h55, 0);
    do_cmd(2'd0, 64'h1, 0, 0);
    do_cmd(2'd1, 64'hffbbbbbbffbbbbbb, 32'h7, 0);
    check("hash_idx", last_idx, 2);
    do_cmd(2'd2, 64'h1, 0, 0);
    do_cmd(2'd1, 64'h3, 32'hC, 0);
    do_cmd(2'd2, 64'h9, 0, 0);
    do_cmd(2'd0, 64'h2, 0, 5);
    do_cmd(2'd0, 64'hdead, 0, 0);

    for (int i = 0; i < 8; i++) pool[i] = {$urandom(), $urandom()};
    pool[0] = 64'h1; pool[1] = 64'h2;
    for (int i = 0; i < 80; i++)
      do_cmd(2'($urandom_range(0, 3)), pool[$urandom_range(0, 7)], $urandom(), 0);

    // Reset while an insert sits in PROBE.
    @(negedge clk);
    bus.cmd_valid = 1; bus.cmd_op = 2'd1; bus.cmd_key = 64'h77; bus.cmd_val = 32'h99;
    @(posedge clk); #1;
    bus.cmd_valid = 0;
    @(posedge clk); #1;
    rst = 1;
    #1;
    check("midrst_occ", bus.occupancy, 0);
    check("midrst_valid", bus.rsp_valid, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    model_clear();
    @(negedge clk);
    check("midrst_ready", bus.cmd_ready, 1);
    do_cmd(2'd0, 64'h77, 0, 0);
    for (int i = 0; i < 8; i++) do_cmd(2'd0, pool[i], 0, 0);
    do_cmd(2'd0, 64'h3, 0, 0);
    do_cmd(2'd1, 64'h77, 32'h5, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/cuckoo_probe_unit.md
# cuckoo_probe_unit

Single-command cuckoo hash probe engine that sits directly downstream of the `default_hash` function. It registers a 64-bit key, computes two multiply-shift bucket indices (one per way), then probes and updates two on-chip bucket tables. It serves lookup, insert-without-eviction and delete commands, and returns the results over a valid/ready response channel. Eviction (kick) chains belong to a separate controller that issues commands to this unit.

## Interface
- `LG_NUM_BUCKETS`, 2: log2 of buckets per way; legal range 1..16.
- `VAL_W`, 32: width of the stored value.
- `COE_A0`, 32'h6f23ffab: way-0 coefficient applied to key[63:32].
- `COE_B0`, 32'h1f23ffab: way-0 coefficient applied to key[31:0].
- `COE_A1`, 32'h1f23ffab: way-1 coefficient applied to key[63:32].
- `COE_B1`, 32'h6f23ffab: way-1 coefficient applied to key[31:0].
- One clock; reset is asynchronous and active-high.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  unit can accept a command.
- `cmd_op`  in  2  operation: 0 = lookup, 1 = insert, 2 = delete, 3 = reserved (executes as lookup).
- `cmd_key`  in  64  key (ADDR_WIDTH).
- `cmd_val`  in  VAL_W  value for insert; ignored for other operations.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_hit`  out  1  key was found in either way (before any update).
- `rsp_full`  out  1  insert failed because both candidate buckets were occupied by other keys.
- `rsp_way`  out  1  way that matched or was written; 0 on a miss or full.
- `rsp_idx`  out  LG_NUM_BUCKETS  bucket index in `rsp_way`; on a miss or full, the way-0 index.
- `rsp_val`  out  VAL_W  stored value on a hit (the old value for an insert overwrite); 0 otherwise.
- `occupancy`  out  LG_NUM_BUCKETS+2  number of valid entries across both ways.

## Operation
- **Hash.** h_w = ((key[63:32]*COE_Aw + key[31:0]*COE_Bw) mod 2^64) >> (64-LG_NUM_BUCKETS).
  - Each product is a 32x32-to-64 unsigned product.
  - The sum is 64-bit and wraps.
  - The index is the top LG_NUM_BUCKETS bits.
- **Tables.** Two arrays, way 0 and way 1. Each has 2^LG_NUM_BUCKETS entries of {valid, key[63:0], val[VAL_W-1:0]}.
- **FSM states:** IDLE, HASH, PROBE, RESP.
  - IDLE -> HASH on cmd_valid & cmd_ready. The unit latches op, key and val.
  - HASH -> PROBE unconditionally. h0 and h1 are registered here.
  - PROBE -> RESP unconditionally. The table update and the response registers are written on this edge.
  - RESP -> IDLE on rsp_ready.
- **Handshakes.**
  - cmd_ready = (state == IDLE).
  - rsp_valid = (state == RESP).
  - Response fields stay stable while rsp_valid=1 and rsp_ready=0.
- **Match rule.** Way 0 matches if way0[h0].valid and way0[h0].key == key; way 1 likewise with h1. If both match, way 0 wins.
- **Lookup.** No state change.
- **Insert.**
  - Key found: overwrite the value in place; occupancy is unchanged.
  - Key not found, way0[h0] empty: write to way 0; occupancy +1.
  - Key not found, way0[h0] occupied, way1[h1] empty: write to way 1; occupancy +1.
  - Key not found, both occupied: rsp_full=1 and no write.
- **Delete.** On a hit, clear the matching entry's valid bit and decrement occupancy. On a miss, no change.
- **Reserved op (3).** Executes exactly as a lookup.

## Timing
- Reset values:
  - state = IDLE; cmd_ready = 1 once rst deasserts.
  - rsp_valid, rsp_hit, rsp_full and rsp_way = 0; rsp_idx = 0; rsp_val = 0.
  - occupancy = 0; every valid bit in both ways = 0.
- Reset mid-operation aborts the in-flight command. No table write occurs after rst asserts.
- Latency: with the accept edge counted as edge 1, rsp_valid rises after edge 3.
- A table write is visible to the next accepted command.
- Peak throughput is one command per 4 cycles when rsp_ready is held high.
- A command presented while the unit is busy is held off by cmd_ready=0 and is not sampled.
- occupancy never exceeds 2*2^LG_NUM_BUCKETS and never wraps below 0.

## Test plan
- **Reset.** After reset, lookup key 64'h1 -> rsp_hit=0, rsp_idx=0, rsp_way=0, occupancy=0; rsp_valid rises after edge 3.
- **Collision fill.** Insert keys 1, 2, 3 with values 'hA, 'hB, 'hC. All hash to index 0 in both ways.
  - Key 1 -> way 0, idx 0.
  - Key 2 -> way 1, idx 0.
  - Key 3 -> rsp_full=1, no write.
  - occupancy=2.
- **Overwrite.** Insert key 1 with 'h55 -> rsp_hit=1, rsp_val='hA, occupancy stays 2. A following lookup of key 1 -> rsp_val='h55, rsp_way=0.
- **Hash value.** Insert key 64'hffbbbbbbffbbbbbb with LG_NUM_BUCKETS=2 -> rsp_idx=2, way 0.
- **Delete and refill.** Delete key 1 -> rsp_hit=1, occupancy=1. Insert key 3 -> way 0, idx 0. Delete key 9 (absent) -> rsp_hit=0, no change.
- **Backpressure and reset.**
  - Hold rsp_ready=0 for 5 cycles: the response stays stable and cmd_ready=0.
  - Assert rst while the FSM is in PROBE on an insert -> no write occurs; occupancy=0 and all valid bits are cleared.
